// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and constants for the two-master CPU memory arbiter.
package cpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_AUX = 1'b1;

endpackage

// File: rtl/cpu_mem_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins, on contention the master
// that was not granted last time wins.
module rr_arbiter2
    import cpu_mem_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |valid;
        grant       = MST_CPU;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else if (valid[1]) begin
            grant = MST_AUX;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares the single-port CPU memory between the core (master 0) and an
// auxiliary master, with a locked round-robin grant and a per-access timeout.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        err_pulse,
    output logic        err_master
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       last_grant;
    logic       grant_r;
    logic       grant;
    logic       grant_valid;

    rr_arbiter2 u_arb (
        .valid       ({m1_valid, m0_valid}),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= MST_AUX;
            grant_r    <= MST_CPU;
            s_valid    <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wstrb    <= '0;
            m0_ready   <= 1'b0;
            m1_ready   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            err_pulse  <= 1'b0;
            err_master <= 1'b0;
        end else begin
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
            err_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        grant_r    <= grant;
                        last_grant <= grant;
                        s_addr     <= (grant == MST_AUX) ? m1_addr  : m0_addr;
                        s_wdata    <= (grant == MST_AUX) ? m1_wdata : m0_wdata;
                        s_wstrb    <= (grant == MST_AUX) ? m1_wstrb : m0_wstrb;
                        s_valid    <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // An ack in the timeout cycle wins over the abort.
                    if (s_ready) begin
                        s_valid <= 1'b0;
                        if (s_wstrb == 4'd0) begin
                            if (grant_r == MST_AUX) m1_rdata <= s_rdata;
                            else                    m0_rdata <= s_rdata;
                        end
                        m0_ready <= (grant_r == MST_CPU);
                        m1_ready <= (grant_r == MST_AUX);
                        state    <= ST_RESP;
                    end else if (cnt == TO_LAST) begin
                        s_valid    <= 1'b0;
                        if (grant_r == MST_AUX) m1_rdata <= ERR_RDATA;
                        else                    m0_rdata <= ERR_RDATA;
                        err_pulse  <= 1'b1;
                        err_master <= grant_r;
                        m0_ready   <= (grant_r == MST_CPU);
                        m1_ready   <= (grant_r == MST_AUX);
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
